axil_write_ctrl: RTL and testbench

AXIL_WRITE_CTRL -- requirements
Module: axil_write_ctrl

---
 rtl/axil_write_ctrl.sv | 140 ++++++++++++++
 tb/tb_axil_write_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_write_ctrl.sv
// AXI4-Lite write-channel controller: joins AW and W into one request towards a
// register file, waits for its ack (with an optional watchdog) and returns a B response.
module axil_write_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic                      err_write_i,
    output logic                      wr_req_o,
    output logic [ADDR_WIDTH-1:0]     wr_addr_o,
    output logic [DATA_WIDTH-1:0]     wr_data_o,
    output logic [DATA_WIDTH/8-1:0]   wr_strb_o,
    input  logic                      wr_ack_i
);

    localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_e;

    state_e                    state_q, state_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      wr_req_q, wr_req_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [DATA_WIDTH/8-1:0]   strb_q, strb_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic                      accept;

    // Reset is folded in so the readies stay low while reset is held, even with valids up.
    assign accept        = s_axi_aresetn && (state_q == ST_IDLE) && s_axi_awvalid && s_axi_wvalid;
    assign s_axi_awready = accept;
    assign s_axi_wready  = accept;

    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign wr_req_o      = wr_req_q;
    assign wr_addr_o     = addr_q;
    assign wr_data_o     = data_q;
    assign wr_strb_o     = strb_q;

    always_comb begin
        state_d  = state_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        wr_req_d = wr_req_q;
        addr_d   = addr_q;
        data_d   = data_q;
        strb_d   = strb_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d = s_axi_awaddr;
                    data_d = s_axi_wdata;
                    strb_d = s_axi_wstrb;
                    cnt_d  = '0;
                    if (err_write_i) begin
                        state_d  = ST_RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_SLVERR;
                    end else begin
                        state_d  = ST_REQ;
                        wr_req_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // Ack wins over a watchdog expiry landing in the same cycle.
                if (wr_ack_i) begin
                    state_d  = ST_RESP;
                    wr_req_d = 1'b0;
                    bvalid_d = 1'b1;
                    bresp_d  = RESP_OKAY;
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
                    state_d  = ST_RESP;
                    wr_req_d = 1'b0;
                    bvalid_d = 1'b1;
                    bresp_d  = RESP_SLVERR;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (s_axi_bready) begin
                    state_d  = ST_IDLE;
                    bvalid_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bvalid_d = 1'b0;
                wr_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q  <= ST_IDLE;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            wr_req_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            wr_req_q <= wr_req_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            strb_q   <= strb_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axil_write_ctrl.sv
// Directed bench for axil_write_ctrl: a transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_axil_write_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] awaddr = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b1;
    logic          err = 1'b0;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic          ack = 1'b0;

    int tests = 0;
    int fails = 0;
    int req_hi_cnt = 0;
    int bv_hi_cnt = 0;
    int r0;
    int b0;

    // Model state: what the outputs must be, derived from the transaction rules.
    logic          m_req = 1'b0;
    logic          m_bvalid = 1'b0;
    logic [1:0]    m_bresp = 2'b00;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [SW-1:0] m_strb = '0;
    int            m_age = 0;
    logic          exp_rdy;

    axil_write_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .err_write_i   (err),
        .wr_req_o      (wr_req),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .wr_strb_o     (wr_strb),
        .wr_ack_i      (ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic aw, input logic w, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic [SW-1:0] strb,
                                 input logic e);
        awvalid = aw;
        wvalid  = w;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        err     = e;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: a write is outstanding while m_req, a response while m_bvalid; m_age counts request cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req    = 1'b0;
            m_bvalid = 1'b0;
            m_bresp  = 2'b00;
            m_addr   = '0;
            m_data   = '0;
            m_strb   = '0;
            m_age    = 0;
        end else if (!m_req && !m_bvalid) begin
            if (awvalid && wvalid) begin
                m_addr = awaddr;
                m_data = wdata;
                m_strb = wstrb;
                if (err) begin
                    m_bvalid = 1'b1;
                    m_bresp  = 2'b10;
                end else begin
                    m_req = 1'b1;
                    m_age = 1;
                end
            end
        end else if (m_req) begin
            if (ack) begin
                m_req    = 1'b0;
                m_bvalid = 1'b1;
                m_bresp  = 2'b00;
            end else if (m_age == TO) begin
                m_req    = 1'b0;
                m_bvalid = 1'b1;
                m_bresp  = 2'b10;
            end else begin
                m_age = m_age + 1;
            end
        end else if (bready) begin
            m_bvalid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (wr_req) req_hi_cnt++;
        if (bvalid) bv_hi_cnt++;
        exp_rdy = rst_n && !m_req && !m_bvalid && awvalid && wvalid;
        checkOutput("cyc_awready", 64'(awready), 64'(exp_rdy));
        checkOutput("cyc_wready", 64'(wready), 64'(exp_rdy));
        checkOutput("cyc_wr_req", 64'(wr_req), 64'(m_req));
        checkOutput("cyc_bvalid", 64'(bvalid), 64'(m_bvalid));
        checkOutput("cyc_wr_addr", 64'(wr_addr), 64'(m_addr));
        checkOutput("cyc_wr_data", 64'(wr_data), 64'(m_data));
        checkOutput("cyc_wr_strb", 64'(wr_strb), 64'(m_strb));
        if (m_bvalid) checkOutput("cyc_bresp", 64'(bresp), 64'(m_bresp));
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        // Reset state
        step();
        step();
        checkOutput("rst_wr_req", 64'(wr_req), 64'd0);
        checkOutput("rst_bvalid", 64'(bvalid), 64'd0);
        checkOutput("rst_addr", 64'(wr_addr), 64'd0);
        checkOutput("rst_awready", 64'(awready), 64'd0);
        rst_n = 1'b1;
        step();

        // Normal write, ack during third request cycle
        applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        #1 checkOutput("s1_awready_comb", 64'(awready), 64'd1);
        r0 = req_hi_cnt;
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("s1_wr_req", 64'(wr_req), 64'd1);
        checkOutput("s1_addr", 64'(wr_addr), 64'h10);
        checkOutput("s1_data", 64'(wr_data), 64'hDEADBEEF);
        checkOutput("s1_strb", 64'(wr_strb), 64'hF);
        step();
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        checkOutput("s1_bvalid", 64'(bvalid), 64'd1);
        checkOutput("s1_bresp", 64'(bresp), 64'd0);
        checkOutput("s1_wr_req_fall", 64'(wr_req), 64'd0);
        checkOutput("s1_req_cycles", 64'(req_hi_cnt - r0), 64'd3);
        step();
        checkOutput("s1_bvalid_done", 64'(bvalid), 64'd0);

        // Error flagged on handshake: immediate SLVERR, no request
        r0 = req_hi_cnt;
        applyStimulus(1, 1, 32'h12, 32'h11223344, 4'h3, 1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("s2_bvalid", 64'(bvalid), 64'd1);
        checkOutput("s2_bresp", 64'(bresp), 64'h2);
        checkOutput("s2_wr_req", 64'(wr_req), 64'd0);
        checkOutput("s2_addr", 64'(wr_addr), 64'h12);
        step();
        checkOutput("s2_bvalid_done", 64'(bvalid), 64'd0);
        checkOutput("s2_req_cycles", 64'(req_hi_cnt - r0), 64'd0);

        // Watchdog expiry, then a late ack that must be ignored
        bready = 1'b0;
        r0 = req_hi_cnt;
        applyStimulus(1, 1, 32'h20, 32'hCAFEF00D, 4'hC, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (4) step();
        checkOutput("s3_bvalid", 64'(bvalid), 64'd1);
        checkOutput("s3_bresp", 64'(bresp), 64'h2);
        checkOutput("s3_wr_req", 64'(wr_req), 64'd0);
        checkOutput("s3_req_cycles", 64'(req_hi_cnt - r0), 64'd4);
        ack = 1'b1;
        step();
        ack = 1'b0;
        checkOutput("s3_late_bvalid", 64'(bvalid), 64'd1);
        checkOutput("s3_late_bresp", 64'(bresp), 64'h2);
        bready = 1'b1;
        step();
        checkOutput("s3_bvalid_done", 64'(bvalid), 64'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        checkOutput("s3_idle_ack_bvalid", 64'(bvalid), 64'd0);
        checkOutput("s3_idle_ack_req", 64'(wr_req), 64'd0);

        // Ack coincides with watchdog expiry: OKAY wins
        r0 = req_hi_cnt;
        applyStimulus(1, 1, 32'h30, 32'h0BADC0DE, 4'h1, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (3) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        checkOutput("s4_bvalid", 64'(bvalid), 64'd1);
        checkOutput("s4_bresp", 64'(bresp), 64'd0);
        checkOutput("s4_req_cycles", 64'(req_hi_cnt - r0), 64'd4);
        step();

        // AW alone for 5 cycles, then W; B held off for 3 cycles
        bready = 1'b0;
        applyStimulus(1, 0, 32'h40, 32'h55AA55AA, 4'hF, 0);
        for (int i = 0; i < 5; i++) begin
            #1 checkOutput("s5_lone_aw_ready", 64'(awready), 64'd0);
            step();
        end
        applyStimulus(1, 1, 32'h40, 32'h55AA55AA, 4'hF, 0);
        #1 checkOutput("s5_joint_ready", 64'(awready), 64'd1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        b0 = bv_hi_cnt;
        checkOutput("s5_bvalid", 64'(bvalid), 64'd1);
        step();
        step();
        bready = 1'b1;
        applyStimulus(1, 1, 32'h44, 32'h12345678, 4'hA, 0);
        #1 checkOutput("s5_ready_in_resp", 64'(awready), 64'd0);
        step();
        checkOutput("s5_bvalid_done", 64'(bvalid), 64'd0);
        checkOutput("s5_bvalid_cycles", 64'(bv_hi_cnt - b0), 64'd3);
        #1 checkOutput("s5_next_ready", 64'(wready), 64'd1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("s5_next_req", 64'(wr_req), 64'd1);
        checkOutput("s5_next_addr", 64'(wr_addr), 64'h44);
        ack = 1'b1;
        step();
        ack = 1'b0;
        checkOutput("s5_next_bresp", 64'(bresp), 64'd0);
        step();

        // Reset in the middle of a request
        applyStimulus(1, 1, 32'h50, 32'h87654321, 4'hF, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("s6_wr_req", 64'(wr_req), 64'd1);
        #2 rst_n = 1'b0;
        applyStimulus(1, 1, 32'h58, 32'h0, 4'h0, 0);
        #1;
        checkOutput("s6_rst_wr_req", 64'(wr_req), 64'd0);
        checkOutput("s6_rst_addr", 64'(wr_addr), 64'd0);
        checkOutput("s6_rst_data", 64'(wr_data), 64'd0);
        checkOutput("s6_rst_strb", 64'(wr_strb), 64'd0);
        checkOutput("s6_rst_bvalid", 64'(bvalid), 64'd0);
        checkOutput("s6_rst_awready", 64'(awready), 64'd0);
        checkOutput("s6_rst_wready", 64'(wready), 64'd0);
        step();
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        step();
        checkOutput("s6_no_stale_b", 64'(bvalid), 64'd0);
        applyStimulus(1, 1, 32'h60, 32'hA5A5A5A5, 4'h5, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("s6_post_addr", 64'(wr_addr), 64'h60);
        ack = 1'b1;
        step();
        ack = 1'b0;
        checkOutput("s6_post_bvalid", 64'(bvalid), 64'd1);
        checkOutput("s6_post_bresp", 64'(bresp), 64'd0);
        step();
        checkOutput("s6_post_done", 64'(bvalid), 64'd0);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
